// File: rtl/ram_log_pkg.sv
// ram_log_pkg: shared definitions for ram_log_ctrl.
//   state_t : FSM state encoding, 3 bits (ST_IDLE..ST_RD_OUT)
//   DEPTH   : default log depth (2**15 words); ram_log_ctrl derives its default NB_ADDR from it
package ram_log_pkg;

   localparam int NB_ADDR_DFLT = 15;
   localparam int DEPTH        = 2 ** NB_ADDR_DFLT;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_RD_REQ  = 3'd2,
      ST_RD_WAIT = 3'd3,
      ST_RD_OUT  = 3'd4
   } state_t;

endpackage

// File: rtl/ram_log_ctrl.sv
// ram_log_ctrl: capture/readout controller for a block RAM with a 1-cycle read latency.
//   Logs a qualified sample stream into RAM, then on request streams the log back out
//   on a valid/ready port, one word per three cycles when the consumer is always ready.
// Ports:
//   clock, i_reset_n                    clock and asynchronous active-low reset
//   i_start_log, i_stop_log, i_read_log command pulses
//   i_data, i_data_valid                sample input
//   o_ram_wr_data/addr/en               RAM write port
//   o_ram_rd_addr/en, i_ram_rd_data     RAM read port (data returns one cycle after o_ram_rd_en)
//   o_data, o_valid, i_ready            readout stream
//   o_busy, o_mem_full, o_done          status
// Configuration:
//   LOG_WRAP_EN defined   : circular log; capture continues past full, overwriting the oldest words,
//                           and readout begins at the oldest word.
//   LOG_WRAP_EN undefined : linear log; capture stops at full and readout begins at address 0.
module ram_log_ctrl
   import ram_log_pkg::*;
#(
   parameter int NB_ADDR = $clog2(DEPTH),
   parameter int NB_DATA = 14
) (
   input  logic               clock,
   input  logic               i_reset_n,
   input  logic               i_start_log,
   input  logic               i_stop_log,
   input  logic               i_read_log,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_data_valid,
   output logic [NB_DATA-1:0] o_ram_wr_data,
   output logic [NB_ADDR-1:0] o_ram_wr_addr,
   output logic               o_ram_wr_en,
   output logic [NB_ADDR-1:0] o_ram_rd_addr,
   output logic               o_ram_rd_en,
   input  logic [NB_DATA-1:0] i_ram_rd_data,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_busy,
   output logic               o_mem_full,
   output logic               o_done
);

`ifdef LOG_WRAP_EN
   localparam bit LP_WRAP = 1'b1;
`else
   localparam bit LP_WRAP = 1'b0;
`endif
   localparam logic [NB_ADDR:0] LP_FULL = {1'b1, {NB_ADDR{1'b0}}};

   state_t             r_state, w_state_nxt;
   logic [NB_ADDR-1:0] r_wr_ptr, r_rd_addr, r_wr_addr;
   logic [NB_ADDR:0]   r_cnt, r_rd_cnt, w_cnt_inc, w_rd_cnt_inc;
   logic [NB_DATA-1:0] r_wr_data, r_data;
   logic               r_mem_full, r_wr_en, r_valid, r_done;
   logic               w_start, w_write, w_hit_full, w_rd_start, w_rd_empty, w_accept, w_last_rd;

   assign w_cnt_inc    = r_cnt + 1'b1;
   assign w_rd_cnt_inc = r_rd_cnt + 1'b1;
   assign w_start      = (r_state == ST_IDLE) & i_start_log;
   // start has priority over read when both arrive together
   assign w_rd_start   = (r_state == ST_IDLE) & i_read_log & ~i_start_log & (r_cnt != '0);
   assign w_rd_empty   = (r_state == ST_IDLE) & i_read_log & ~i_start_log & (r_cnt == '0);
   assign w_write      = (r_state == ST_CAPTURE) & i_data_valid;
   // fires only on the write that brings the count to DEPTH; cnt saturates afterwards
   assign w_hit_full   = w_write & (w_cnt_inc == LP_FULL);
   assign w_accept     = (r_state == ST_RD_OUT) & i_ready;
   assign w_last_rd    = w_accept & (w_rd_cnt_inc == r_cnt);

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    w_state_nxt = w_start ? ST_CAPTURE : (w_rd_start ? ST_RD_REQ : ST_IDLE);
         ST_CAPTURE: w_state_nxt = (i_stop_log | (w_hit_full & ~LP_WRAP)) ? ST_IDLE : ST_CAPTURE;
         ST_RD_REQ:  w_state_nxt = ST_RD_WAIT;
         ST_RD_WAIT: w_state_nxt = ST_RD_OUT;
         ST_RD_OUT:  w_state_nxt = w_accept ? (w_last_rd ? ST_IDLE : ST_RD_REQ) : ST_RD_OUT;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr   <= '0;
         r_cnt      <= '0;
         r_rd_cnt   <= '0;
         r_rd_addr  <= '0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_en    <= 1'b0;
         r_mem_full <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_wr_en <= w_write;
         r_done  <= w_rd_empty | w_last_rd;
         if (w_start) begin
            r_wr_ptr   <= '0;
            r_cnt      <= '0;
            r_mem_full <= 1'b0;
         end
         if (w_write) begin
            r_wr_addr <= r_wr_ptr;
            r_wr_data <= i_data;
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_cnt     <= (r_cnt == LP_FULL) ? r_cnt : w_cnt_inc;
         end
         if (w_hit_full) r_mem_full <= 1'b1;
         // a full circular log has its oldest word at the write pointer
         if (w_rd_start) begin
            r_rd_addr <= (LP_WRAP && r_mem_full) ? r_wr_ptr : '0;
            r_rd_cnt  <= '0;
         end
         if (r_state == ST_RD_WAIT) begin
            r_data  <= i_ram_rd_data;
            r_valid <= 1'b1;
         end
         if (w_accept) begin
            r_valid   <= 1'b0;
            r_rd_cnt  <= w_rd_cnt_inc;
            r_rd_addr <= r_rd_addr + 1'b1;
         end
      end
   end

   assign o_ram_wr_data = r_wr_data;
   assign o_ram_wr_addr = r_wr_addr;
   assign o_ram_wr_en   = r_wr_en;
   assign o_ram_rd_addr = r_rd_addr;
   assign o_ram_rd_en   = (r_state == ST_RD_REQ);
   assign o_data        = r_data;
   assign o_valid       = r_valid;
   assign o_busy        = (r_state != ST_IDLE);
   assign o_mem_full    = r_mem_full;
   assign o_done        = r_done;

endmodule

// File: tb/tb_ram_log_ctrl.sv
// tb_ram_log_ctrl: self-checking bench for ram_log_ctrl (NB_ADDR=3, NB_DATA=8) with a block RAM model.
//   Expectations follow LOG_WRAP_EN the same way the design does.
module tb_ram_log_ctrl;

   localparam int NA = 3;
   localparam int ND = 8;
   localparam int DEP = 8;
`ifdef LOG_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          i_reset_n = 1'b0;
   logic          i_start_log = 1'b0, i_stop_log = 1'b0, i_read_log = 1'b0;
   logic [ND-1:0] i_data = '0;
   logic          i_data_valid = 1'b0;
   logic [ND-1:0] o_ram_wr_data, i_ram_rd_data, o_data;
   logic [NA-1:0] o_ram_wr_addr, o_ram_rd_addr;
   logic          o_ram_wr_en, o_ram_rd_en, o_valid, o_busy, o_mem_full, o_done;
   logic          i_ready = 1'b1;

   ram_log_ctrl #(.NB_ADDR(NA), .NB_DATA(ND)) dut (
      .clock(clock), .i_reset_n(i_reset_n),
      .i_start_log(i_start_log), .i_stop_log(i_stop_log), .i_read_log(i_read_log),
      .i_data(i_data), .i_data_valid(i_data_valid),
      .o_ram_wr_data(o_ram_wr_data), .o_ram_wr_addr(o_ram_wr_addr), .o_ram_wr_en(o_ram_wr_en),
      .o_ram_rd_addr(o_ram_rd_addr), .o_ram_rd_en(o_ram_rd_en), .i_ram_rd_data(i_ram_rd_data),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_busy(o_busy), .o_mem_full(o_mem_full), .o_done(o_done)
   );

   always #5 clock = ~clock;

   logic [ND-1:0] mem [DEP];
   always @(posedge clock) begin
      if (o_ram_wr_en) mem[o_ram_wr_addr] <= o_ram_wr_data;
      if (o_ram_rd_en) i_ram_rd_data <= mem[o_ram_rd_addr];
   end

   int errors = 0, checks = 0;
   int done_cnt = 0, rd_en_cnt = 0, valid_cnt = 0, stall_cnt = 0;
   logic [ND-1:0] log_q[$], exp_q[$], got_q[$];
   bit capturing = 0, full = 0;
   logic prev_stall = 1'b0;
   logic [ND-1:0] prev_data = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // readout stream checker against the expected-log queue
   always @(negedge clock) begin
      if (o_ram_rd_en) rd_en_cnt++;
      if (o_valid) valid_cnt++;
      if (o_valid && !i_ready) stall_cnt++;
      if (prev_stall && i_reset_n) begin
         chk("hold_valid", o_valid, 1);
         chk("hold_data", o_data, prev_data);
      end
      prev_stall = i_reset_n && o_valid && !i_ready;
      prev_data  = o_data;
      if (o_valid && i_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_word: got %0h expected none", o_data);
         end else begin
            logic [ND-1:0] e;
            e = exp_q.pop_front();
            if (o_data !== e) begin
               errors++;
               $display("FAIL word: got %0h expected %0h", o_data, e);
            end
         end
         got_q.push_back(o_data);
      end
      if (o_done) begin
         done_cnt++;
         chk("done_remaining", exp_q.size(), 0);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_log(input bit with_read);
      i_start_log = 1; i_read_log = with_read;
      tick();
      i_start_log = 0; i_read_log = 0;
      log_q = {}; capturing = 1; full = 0;
   endtask

   task automatic sample(input logic [ND-1:0] d, input bit stop);
      i_data = d; i_data_valid = 1; i_stop_log = stop;
      tick();
      i_data_valid = 0; i_stop_log = 0;
      if (capturing) begin
         log_q.push_back(d);
         if (log_q.size() > DEP) void'(log_q.pop_front());
         if (log_q.size() == DEP) begin
            full = 1;
            if (!WRAP) capturing = 0;
         end
      end
      if (stop) capturing = 0;
   endtask

   task automatic stop_log();
      i_stop_log = 1; tick(); i_stop_log = 0;
      capturing = 0;
   endtask

   task automatic do_read(input int stall_word, input int stall_len, output int n);
      int left, base;
      left = stall_len; base = done_cnt;
      exp_q = log_q; got_q = {};
      i_read_log = 1; tick(); i_read_log = 0;
      n = 0;
      while (done_cnt == base && n < 300) begin
         i_ready = !(o_valid && got_q.size() == stall_word && left > 0);
         if (!i_ready) left--;
         tick(); n++;
      end
      i_ready = 1;
      chk("read_done_once", done_cnt - base, 1);
   endtask

   initial begin
      int n, s0, v0, r0, d0;
      tick();
      chk("rst_valid", o_valid, 0);
      chk("rst_done", o_done, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_full", o_mem_full, 0);
      chk("rst_wr_en", o_ram_wr_en, 0);
      chk("rst_rd_en", o_ram_rd_en, 0);
      chk("rst_addrs", {o_ram_wr_addr, o_ram_rd_addr}, 0);
      chk("rst_data", o_data, 0);
      i_reset_n = 1; tick();

      // 1: five samples, last one together with stop
      start_log(0);
      chk("t1_busy", o_busy, 1);
      for (int i = 0; i < 4; i++) sample(ND'(8'h10 + i), 0);
      sample(8'h14, 1);
      tick();
      chk("t1_idle", o_busy, 0);
      chk("t1_full", o_mem_full, 0);
      do_read(-1, 0, n);
      chk("t1_count", got_q.size(), 5);
      chk("t1_first", got_q[0], 8'h10);
      chk("t1_last", got_q[4], 8'h14);
      chk("t1_cycles", n, 16);

      // 2: stall four cycles on the second word
      s0 = stall_cnt;
      do_read(1, 4, n);
      chk("t2_stalls", stall_cnt - s0, 4);
      chk("t2_count", got_q.size(), 5);
      chk("t2_word2", got_q[1], 8'h11);

      // 3/4: overflow with ten samples; start and read together must start capture
      start_log(1);
      chk("t3_busy", o_busy, 1);
      for (int i = 0; i < 10; i++) sample(ND'(i), 0);
      tick();
      chk("t3_full", o_mem_full, 1);
      chk("t3_full_model", o_mem_full, full);
      chk("t3_busy_after", o_busy, WRAP);
      stop_log();
      tick();
      chk("t3_idle", o_busy, 0);
      do_read(-1, 0, n);
      chk("t3_count", got_q.size(), 8);
      chk("t3_first", got_q[0], WRAP ? 8'h02 : 8'h00);
      chk("t3_last", got_q[7], WRAP ? 8'h09 : 8'h07);

      // 5: read with an empty log
      start_log(0);
      stop_log();
      r0 = rd_en_cnt; v0 = valid_cnt;
      exp_q = {};
      i_read_log = 1; tick(); i_read_log = 0;
      chk("t5_done", o_done, 1);
      chk("t5_busy", o_busy, 0);
      tick();
      chk("t5_done_pulse", o_done, 0);
      chk("t5_no_rd", rd_en_cnt - r0, 0);
      chk("t5_no_valid", valid_cnt - v0, 0);

      // 6: reset during RD_OUT
      start_log(0);
      for (int i = 0; i < 3; i++) sample(ND'(8'h30 + i), 0);
      stop_log();
      exp_q = log_q;
      d0 = done_cnt;
      i_ready = 0;
      i_read_log = 1; tick(); i_read_log = 0;
      n = 0;
      while (!o_valid && n < 10) begin tick(); n++; end
      chk("t6_valid_seen", o_valid, 1);
      i_reset_n = 0; #1;
      chk("t6_valid", o_valid, 0);
      chk("t6_busy", o_busy, 0);
      exp_q = {}; log_q = {};
      tick();
      chk("t6_valid_next", o_valid, 0);
      chk("t6_no_done", done_cnt - d0, 0);
      i_reset_n = 1; i_ready = 1;
      tick();
      v0 = valid_cnt; r0 = rd_en_cnt;
      i_read_log = 1; tick(); i_read_log = 0;
      chk("t6_empty_done", o_done, 1);
      tick(); tick();
      chk("t6_no_valid", valid_cnt - v0, 0);
      chk("t6_no_rd", rd_en_cnt - r0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
